// File: rtl/vm_key_conditioner.sv
// vm_key_conditioner: front-end for the vending machine's five raw inputs.
// Each channel is synchronised (2 flops), debounced (DB_CYCLES stable samples)
// and turned into a pending press on its accepted rising level. A registered
// fixed-priority arbiter issues at most one one-cycle pulse per clock.
// Priority: cancel > ten_yuan > one_yuan > buy_g1 > buy_g2. While inhibit is
// high only cancel may be issued; other presses stay pending.
// Optional feature macro: VM_KEY_DROP_COUNT_EN adds drop_cnt[7:0], a
// saturating count of cycles in which a press was merged into a pending one.
// Reset is synchronous and active-low.

module vm_key_conditioner #(
    parameter int unsigned DB_CYCLES = 1000000,
    parameter int unsigned CNT_W     = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       one_yuan_raw,
    input  logic       ten_yuan_raw,
    input  logic       cancel_raw,
    input  logic       buy_g1_raw,
    input  logic       buy_g2_raw,
    input  logic       inhibit,
    output logic       one_yuan,
    output logic       ten_yuan,
    output logic       cancel,
    output logic       buy_g1,
    output logic       buy_g2,
    output logic       overrun
`ifdef VM_KEY_DROP_COUNT_EN
    ,
    output logic [7:0] drop_cnt
`endif
);

    // Channel index doubles as priority rank: lower index wins.
    localparam int NumCh    = 5;
    localparam int ChCancel = 0;
    localparam int ChTen    = 1;
    localparam int ChOne    = 2;
    localparam int ChG1     = 3;
    localparam int ChG2     = 4;

    localparam logic [CNT_W-1:0] CntMax = CNT_W'(DB_CYCLES - 1);

    logic [NumCh-1:0] raw_vec;
    logic [NumCh-1:0] sync1_q;
    logic [NumCh-1:0] sync2_q;
    logic [NumCh-1:0] stable_q;
    logic [NumCh-1:0] stable_d;
    logic [CNT_W-1:0] cnt_q [NumCh];
    logic [CNT_W-1:0] cnt_d [NumCh];
    logic [NumCh-1:0] rise;
    logic [NumCh-1:0] merge;
    logic [NumCh-1:0] pending_q;
    logic [NumCh-1:0] pending_d;
    logic [NumCh-1:0] eligible;
    logic [NumCh-1:0] grant;
    logic [NumCh-1:0] pulse_q;
    logic             overrun_q;
    logic             overrun_d;

    assign raw_vec[ChCancel] = cancel_raw;
    assign raw_vec[ChTen]    = ten_yuan_raw;
    assign raw_vec[ChOne]    = one_yuan_raw;
    assign raw_vec[ChG1]     = buy_g1_raw;
    assign raw_vec[ChG2]     = buy_g2_raw;

    // Debounce: accept a level only after DB_CYCLES consecutive differing samples.
    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < NumCh; i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync2_q[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CntMax) begin
                stable_d[i] = sync2_q[i];
                cnt_d[i]    = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    // A press is the accepted 0->1 edge; releases generate nothing.
    assign rise  = stable_d & ~stable_q;
    // A press landing on an already pending channel is folded into it.
    assign merge = rise & pending_q;

    // Arbitration: while inhibited only cancel competes.
    always_comb begin
        eligible = pending_q;
        if (inhibit) begin
            eligible           = '0;
            eligible[ChCancel] = pending_q[ChCancel];
        end
        grant = '0;
        for (int i = 0; i < NumCh; i++) begin
            if (eligible[i] && (grant == '0)) begin
                grant[i] = 1'b1;
            end
        end
    end

    // Pending bookkeeping and sticky overrun.
    always_comb begin
        pending_d = (pending_q | rise) & ~grant;
        overrun_d = overrun_q | (|merge);
    end

    // State registers: sync chain, debounce, pending, pulses, overrun.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            stable_q  <= '0;
            pending_q <= '0;
            pulse_q   <= '0;
            overrun_q <= 1'b0;
            for (int i = 0; i < NumCh; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q   <= raw_vec;
            sync2_q   <= sync1_q;
            stable_q  <= stable_d;
            pending_q <= pending_d;
            pulse_q   <= grant;
            overrun_q <= overrun_d;
            for (int i = 0; i < NumCh; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

`ifdef VM_KEY_DROP_COUNT_EN
    logic [7:0] drop_cnt_q;

    // Saturating merge counter; simultaneous merges count once.
    always_ff @(posedge clk) begin
        if (!rst) begin
            drop_cnt_q <= 8'd0;
        end else if ((|merge) && (drop_cnt_q != 8'hff)) begin
            drop_cnt_q <= drop_cnt_q + 8'd1;
        end
    end

    assign drop_cnt = drop_cnt_q;
`endif

    assign cancel   = pulse_q[ChCancel];
    assign ten_yuan = pulse_q[ChTen];
    assign one_yuan = pulse_q[ChOne];
    assign buy_g1   = pulse_q[ChG1];
    assign buy_g2   = pulse_q[ChG2];
    assign overrun  = overrun_q;

endmodule

// File: doc/vm_key_conditioner.md
Name: vm_key_conditioner

Overview:
- Front-end conditioner for the vending machine's five raw board inputs: one_yuan, ten_yuan, cancel, buy_g1 and buy_g2.
- Each channel is synchronised, debounced and converted into a single one-cycle press pulse.
- Arbitration guarantees at most one event per cycle, so the VM core never sees two events in the same clock.
- Sits directly upstream of the VM core, whose one_yuan/ten_yuan/cancel/buy_g1/buy_g2 ports it drives.

Parameters:
- DB_CYCLES, 1000000: number of consecutive stable synchronised samples required to accept a level change (10 ms at 100 MHz). Must be >= 2. Benches use 4.
- CNT_W, 20: width of each debounce counter. Must hold DB_CYCLES-1.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous reset, active-low.
- one_yuan_raw  in  1  raw 1-yuan coin switch, asynchronous.
- ten_yuan_raw  in  1  raw 10-yuan coin switch, asynchronous.
- cancel_raw  in  1  raw cancel button, asynchronous.
- buy_g1_raw  in  1  raw buy-good-1 button, asynchronous.
- buy_g2_raw  in  1  raw buy-good-2 button, asynchronous.
- inhibit  in  1  from the VM core (occupy). While high, only cancel may be issued.
- one_yuan  out  1  one-cycle press pulse.
- ten_yuan  out  1  one-cycle press pulse.
- cancel  out  1  one-cycle press pulse.
- buy_g1  out  1  one-cycle press pulse.
- buy_g2  out  1  one-cycle press pulse.
- overrun  out  1  sticky flag: a press arrived while the same channel was still pending.

Behaviour:
- Reset: synchronous and active-low. When rst is low at a clk edge, all sync flops, counters, stable levels and pending bits clear to 0, and every output goes to 0. Reset mid-operation discards all pending presses.
- Per channel:
  - A 2-flop synchroniser produces s1, then s2.
  - Counter cnt:
    - If s2 == stable, cnt <= 0.
    - Else if cnt == DB_CYCLES-1: stable <= s2, cnt <= 0.
    - Else cnt <= cnt+1.
  - Any bounce back to the old level before acceptance restarts the count, so no event is produced.
- Event: the 0->1 transition of stable sets pending on the same edge. The 1->0 transition (release) produces no event.
- Merge:
  - If stable rises while pending is already 1, the press is merged and overrun <= 1.
  - overrun is sticky until reset.
- Arbiter: registered, evaluated every cycle over the pending bits.
  - Fixed priority: cancel > ten_yuan > one_yuan > buy_g1 > buy_g2.
  - Exactly one winner per cycle.
  - The winner's output is high for the next cycle only, and its pending bit clears on the same edge.
  - Losers keep pending and are issued in later cycles in priority order.
- inhibit=1:
  - Only cancel is eligible; all other channels stay pending.
  - Pending presses are issued after inhibit falls, one per cycle.
- Latency: raw rise first sampled at edge k, held steady, no contention and no inhibit. The output pulse is high during the cycle after edge k+DB_CYCLES+2. The pulse is always exactly 1 cycle wide.
- Held key: produces exactly one pulse, with no repeat. A key held through reset release produces one pulse, with the nominal latency counted from the first edge after reset release.
- Simultaneous acceptance on several channels: all are set pending on the same edge and issued on consecutive cycles in priority order.

Optional Feature:
- Macro: VM_KEY_DROP_COUNT_EN.
- Defined:
  - Adds output drop_cnt [7:0], cleared by reset.
  - Increments by 1 on every merged press and saturates at 255.
  - Merges on several channels in the same cycle count as 1.
- Undefined: port absent; only overrun reports merges.

Test Plan (DB_CYCLES=4, 10 ns clk):
- Clean press: rst low 2 cycles, then release; one_yuan_raw high 100 ns from edge k -> one_yuan high for exactly the one cycle after edge k+6; no pulse on release; overrun=0.
- Bounce reject: buy_g1_raw toggled 1,0,1,0 in 20 ns steps, then held 0 -> buy_g1 never asserts.
- Contention: ten_yuan_raw, one_yuan_raw, buy_g2_raw rise on the same cycle, held 100 ns -> ten_yuan, one_yuan, buy_g2 pulse on three consecutive cycles in that order.
- Inhibit: inhibit=1, then press buy_g2_raw and cancel_raw -> cancel pulses at nominal latency; buy_g2 is withheld and pulses the cycle after inhibit falls.
- Overrun: inhibit=1; press, release and re-press one_yuan_raw (each phase 80 ns) -> overrun=1; after inhibit falls, one_yuan pulses once only; with VM_KEY_DROP_COUNT_EN, drop_cnt=1.
- Reset mid-flight: cancel pending under contention, rst low for 1 edge -> all outputs 0; the pending press is lost and no pulse follows.
